note_player: RTL and testbench
==============================

# note_player

Sequences the sine_reader for one note at a time in the music player. Accepts a note number and a duration in beats, looks up the note's phase step, and drives `step_size` and `generate_next_sample` into sine_reader. Relays finished samples to the codec side, counts beats, and signals completion to the song sequencer. Rests, pauses and idle periods still answer every codec request, returning a zero sample.

## Interface

Parameters:
- `NOTE_W`, 6: note number width; note 0 is a rest.
- `DUR_W`, 6: duration width, in beats.
- `STEP_W`, 20: phase step width, unsigned 10.10 fixed point.
- `SAMPLE_W`, 16: signed sample width.

Ports:
- `clk` in 1: system clock; one clock domain only.
- `reset` in 1: asynchronous, active-low reset.
- `play_enable` in 1: 1 = play, 0 = pause.
- `note_to_load` in NOTE_W: note to play.
- `duration_to_load` in DUR_W: note length in beats.
- `load_new_note` in 1: one-cycle pulse that loads a note.
- `beat` in 1: one-cycle pulse, one per beat.
- `generate_next_sample` in 1: one-cycle codec request for a sample.
- `sine_step_size` out STEP_W: to sine_reader `step_size`.
- `sine_generate` out 1: to sine_reader `generate_next_sample`.
- `sine_ready` in 1: from sine_reader `new_sample_ready`.
- `sine_sample` in SAMPLE_W: from sine_reader `sample_out`.
- `sample_out` out SAMPLE_W: sample to the codec.
- `new_sample_ready` out 1: one-cycle strobe; `sample_out` is valid.
- `done_with_note` out 1: one-cycle pulse when the note ends.
- `busy` out 1: high in LOAD and PLAY.

## Operation

- States: IDLE, LOAD, PLAY, DONE.
- IDLE: on `load_new_note`, register note and duration, issue the ROM address, go to LOAD.
- LOAD: latch the ROM step into `sine_step_size`; note 0 gives step 0.
  - Duration 0 goes to DONE.
  - Otherwise load the beat counter with the duration and go to PLAY.
- PLAY:
  - `beat` with `play_enable`=1 decrements the counter.
  - The decrement from 1 to 0 goes to DONE.
  - `beat` while paused is ignored.
- DONE: `done_with_note`=1 for exactly this cycle, `sine_step_size` is cleared to 0, next state is IDLE.
- `load_new_note` in LOAD, PLAY or DONE is ignored; the sequencer waits for `done_with_note`.
- Sample path (independent of beats):
  - A request is "live" when state is PLAY, `play_enable`=1 and note ≠ 0.
  - Live request: set `pending`, pulse `sine_generate` the next cycle.
  - While `pending` is set, the first `sine_ready` copies `sine_sample` into `sample_out`, pulses `new_sample_ready` the next cycle, and clears `pending`.
  - Non-live request: `sample_out`=0 and `new_sample_ready` pulses the next cycle.
  - A request arriving while `pending` is set is dropped.
  - Pause, or a note ending, while `pending` is set does not cancel the request; the sine sample is still forwarded.
- `sine_ready` with `pending` clear is ignored.
- All arithmetic is unsigned, except `sample_out`, which is passed through unchanged.

## Timing

- Reset values: state IDLE; `sine_step_size`, `sample_out` and counters 0; `new_sample_ready`, `done_with_note`, `busy`, `sine_generate` and `pending` all 0.
- Asserting `reset` mid-note aborts immediately. No `done_with_note` is produced.
- Load latency: `load_new_note` at cycle N → LOAD at N+1 → `sine_step_size` valid and state PLAY at N+2.
- Last beat at cycle M → `done_with_note` at M+1 → IDLE at M+2.
- `done_with_note` and `load_new_note` in the same cycle: the load is ignored (state is DONE).
- Request latency: `generate_next_sample` at cycle N → `sine_generate` at N+1. For a non-live request, `new_sample_ready` is at N+1.
- Sine response: `sine_ready` at cycle K → `new_sample_ready` at K+1.
- `beat` and `generate_next_sample` in the same cycle: both are honoured.

## Structure

- Shared include `music_player_defs.vh` holds:
  - the widths;
  - the state encodings;
  - the 64-entry step table contents.
- Sub-module `note_step_rom`: synchronous 64×20 ROM, one-cycle read latency, entry 0 = 0.

## Test plan

- Basic note: reset → load note 6'd49, duration 3, drive 3 beats → `sine_step_size` equals ROM[49] at N+2; one `done_with_note` pulse one cycle after the 3rd beat; `sine_step_size` reads 0 in IDLE.
- Pause: load duration 4, drop `play_enable` across 2 beats → the paused beats are not counted; done arrives after 4 enabled beats; codec requests made while paused return 0.
- Rest: note 0, duration 2, 10 codec requests → no `sine_generate`; 10 `new_sample_ready` pulses with `sample_out`=0, each one cycle after its request.
- Sample relay:
  - Use a sine_reader stub with 3-cycle latency returning 16'h1234.
  - `sample_out`=16'h1234 one cycle after `sine_ready`.
  - A second request while `pending` is set is dropped.
- Boundaries:
  - Duration 0 → `done_with_note` at N+2, no PLAY state.
  - `load_new_note` during PLAY is ignored.
  - `reset` low mid-PLAY → all outputs 0 immediately, no done pulse.

Source files
------------

// File: rtl/note_player_pkg.sv
// rtl/note_player_pkg.sv - shared widths, state encoding and note step table for note_player
// Contents: NOTE_W_C/DUR_W_C/STEP_W_C/SAMPLE_W_C widths, state_e encoding,
// STEP_TABLE (64 x 20-bit unsigned 10.10 phase steps, entry 0 = rest = 0).
package note_player_pkg;

  localparam int NOTE_W_C   = 6;
  localparam int DUR_W_C    = 6;
  localparam int STEP_W_C   = 20;
  localparam int SAMPLE_W_C = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Equal-temperament phase steps, note 49 = A4 (440 Hz), for a 1024-entry
  // sine table played at 48 kHz.
  localparam logic [STEP_W_C-1:0] STEP_TABLE [0:63] = '{
    20'd0,     20'd601,   20'd636,   20'd674,   20'd714,   20'd757,   20'd802,   20'd850,
    20'd900,   20'd954,   20'd1010,  20'd1070,  20'd1134,  20'd1201,  20'd1273,  20'd1349,
    20'd1429,  20'd1514,  20'd1604,  20'd1699,  20'd1800,  20'd1907,  20'd2021,  20'd2141,
    20'd2268,  20'd2403,  20'd2546,  20'd2697,  20'd2858,  20'd3028,  20'd3208,  20'd3398,
    20'd3600,  20'd3815,  20'd4041,  20'd4282,  20'd4536,  20'd4806,  20'd5092,  20'd5394,
    20'd5715,  20'd6055,  20'd6415,  20'd6797,  20'd7201,  20'd7629,  20'd8082,  20'd8563,
    20'd9072,  20'd9612,  20'd10184, 20'd10789, 20'd11431, 20'd12110, 20'd12830, 20'd13593,
    20'd14402, 20'd15258, 20'd16165, 20'd17127, 20'd18145, 20'd19224, 20'd20367, 20'd21578
  };

endpackage

// File: rtl/note_step_rom.sv
// rtl/note_step_rom.sv - synchronous 64x20 note-to-phase-step ROM, one-cycle read latency
// Ports: clk (clock), addr (note number), data (phase step of the note addressed
// on the previous clock edge).
module note_step_rom
  import note_player_pkg::*;
(
  input  logic                clk,
  input  logic [NOTE_W_C-1:0] addr,
  output logic [STEP_W_C-1:0] data
);

  logic [STEP_W_C-1:0] data_q;
  logic [STEP_W_C-1:0] data_d;

  always_comb begin
    data_d = STEP_TABLE[addr];
  end

  // Pure lookup register; its value only matters one cycle after a load.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/note_player.sv
// rtl/note_player.sv - plays one note at a time by sequencing sine_reader
// Ports: clk, reset (async active-low); play_enable, note_to_load,
// duration_to_load, load_new_note, beat from the song sequencer;
// generate_next_sample from the codec; sine_step_size/sine_generate to and
// sine_ready/sine_sample from sine_reader; sample_out/new_sample_ready to the
// codec; done_with_note/busy to the sequencer.
module note_player
  import note_player_pkg::*;
#(
  parameter int NOTE_W   = NOTE_W_C,
  parameter int DUR_W    = DUR_W_C,
  parameter int STEP_W   = STEP_W_C,
  parameter int SAMPLE_W = SAMPLE_W_C
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                play_enable,
  input  logic [NOTE_W-1:0]   note_to_load,
  input  logic [DUR_W-1:0]    duration_to_load,
  input  logic                load_new_note,
  input  logic                beat,
  input  logic                generate_next_sample,
  output logic [STEP_W-1:0]   sine_step_size,
  output logic                sine_generate,
  input  logic                sine_ready,
  input  logic [SAMPLE_W-1:0] sine_sample,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                new_sample_ready,
  output logic                done_with_note,
  output logic                busy
);

  state_e              state_q, state_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic [DUR_W-1:0]    cnt_q, cnt_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                pending_q, pending_d;
  logic                gen_q, gen_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                nsr_q, nsr_d;
  logic [STEP_W-1:0]   rom_data;
  logic                live;

  // The ROM is addressed straight from the input so the step is ready in LOAD.
  note_step_rom u_rom (
    .clk  (clk),
    .addr (note_to_load),
    .data (rom_data)
  );

  assign live = (state_q == ST_PLAY) && play_enable && (note_q != '0);

  always_comb begin
    state_d   = state_q;
    note_d    = note_q;
    cnt_d     = cnt_q;
    step_d    = step_q;
    pending_d = pending_q;
    gen_d     = 1'b0;
    sample_d  = sample_q;
    nsr_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (load_new_note) begin
          note_d  = note_to_load;
          cnt_d   = duration_to_load;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        step_d = rom_data;
        // The counter already holds the duration; zero skips PLAY entirely.
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (beat && play_enable) begin
          cnt_d = cnt_q - DUR_W'(1);
          if (cnt_q == DUR_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        step_d  = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Sample path runs independently of the note state machine. A sine
    // request in flight survives pause and note end, and blocks new requests.
    if (pending_q) begin
      if (sine_ready) begin
        sample_d  = sine_sample;
        nsr_d     = 1'b1;
        pending_d = 1'b0;
      end
    end else if (generate_next_sample) begin
      if (live) begin
        pending_d = 1'b1;
        gen_d     = 1'b1;
      end else begin
        sample_d = '0;
        nsr_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      note_q    <= '0;
      cnt_q     <= '0;
      step_q    <= '0;
      pending_q <= 1'b0;
      gen_q     <= 1'b0;
      sample_q  <= '0;
      nsr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      note_q    <= note_d;
      cnt_q     <= cnt_d;
      step_q    <= step_d;
      pending_q <= pending_d;
      gen_q     <= gen_d;
      sample_q  <= sample_d;
      nsr_q     <= nsr_d;
    end
  end

  assign sine_step_size   = step_q;
  assign sine_generate    = gen_q;
  assign sample_out       = sample_q;
  assign new_sample_ready = nsr_q;
  assign done_with_note   = (state_q == ST_DONE);
  assign busy             = (state_q == ST_LOAD) || (state_q == ST_PLAY);

endmodule

// File: tb/tb_note_player.sv
// tb/tb_note_player.sv - self-checking bench for note_player
module tb_note_player;

  localparam int SZ  = 64;
  localparam int BIG = 32'h3fff_ffff;

  logic        clk = 1'b0;
  logic        reset;
  logic        play_enable;
  logic [5:0]  note_to_load;
  logic [5:0]  duration_to_load;
  logic        load_new_note;
  logic        beat;
  logic        generate_next_sample;
  logic [19:0] sine_step_size;
  logic        sine_generate;
  logic        sine_ready;
  logic [15:0] sine_sample;
  logic [15:0] sample_out;
  logic        new_sample_ready;
  logic        done_with_note;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Scheduled expectations, indexed by cycle number modulo SZ.
  bit          e_nsr [SZ];
  bit          e_gen [SZ];
  bit          e_done [SZ];
  logic [15:0] e_smp [SZ];
  bit          rdy_sched [SZ];

  bit          exp_nsr, exp_gen, exp_done, exp_busy, exp_idle;
  logic [15:0] exp_smp;

  // Note lifetime described by cycle numbers.
  bit          m_active;
  int          m_idle_from, m_play_from, m_done_cyc, m_load_cyc, m_out_until, m_beats;
  logic [5:0]  m_note;
  bit          stub_fixed;

  always #5 clk = ~clk;

  note_player dut (
    .clk                  (clk),
    .reset                (reset),
    .play_enable          (play_enable),
    .note_to_load         (note_to_load),
    .duration_to_load     (duration_to_load),
    .load_new_note        (load_new_note),
    .beat                 (beat),
    .generate_next_sample (generate_next_sample),
    .sine_step_size       (sine_step_size),
    .sine_generate        (sine_generate),
    .sine_ready           (sine_ready),
    .sine_sample          (sine_sample),
    .sample_out           (sample_out),
    .new_sample_ready     (new_sample_ready),
    .done_with_note       (done_with_note),
    .busy                 (busy)
  );

  function automatic void model_reset();
    for (int i = 0; i < SZ; i++) begin
      e_nsr[i] = 1'b0; e_gen[i] = 1'b0; e_done[i] = 1'b0; e_smp[i] = '0; rdy_sched[i] = 1'b0;
    end
    m_active    = 1'b0;
    m_idle_from = cyc;
    m_play_from = BIG;
    m_done_cyc  = 0;
    m_load_cyc  = -10;
    m_out_until = -1;
    m_beats     = 0;
    m_note      = '0;
    sine_ready  = 1'b0;
  endfunction

  // Consumes the inputs of the current cycle and schedules what must follow.
  function automatic void model_step();
    int c    = cyc;
    bit idle = (c >= m_idle_from);
    bit play = m_active && (c >= m_play_from) && (c < m_done_cyc);
    bit live = play && play_enable && (m_note != 6'd0);
    if (play && beat && play_enable) begin
      m_beats = m_beats - 1;
      if (m_beats == 0) begin
        m_done_cyc = c + 1;
        e_done[(c + 1) % SZ] = 1'b1;
        m_idle_from = c + 2;
      end
    end
    if (idle && load_new_note) begin
      m_active    = 1'b1;
      m_note      = note_to_load;
      m_beats     = int'(duration_to_load);
      m_load_cyc  = c;
      m_play_from = c + 2;
      if (duration_to_load == 6'd0) begin
        m_done_cyc  = c + 2;
        e_done[(c + 2) % SZ] = 1'b1;
        m_idle_from = c + 3;
      end else begin
        m_done_cyc  = BIG;
        m_idle_from = BIG;
      end
    end
    if (generate_next_sample && (c > m_out_until)) begin
      if (live) begin
        // sine_reader stub answers 3 cycles after its strobe.
        sine_sample = stub_fixed ? 16'h1234 : 16'($urandom);
        e_gen[(c + 1) % SZ] = 1'b1;
        m_out_until = c + 4;
        e_nsr[(c + 5) % SZ] = 1'b1;
        e_smp[(c + 5) % SZ] = sine_sample;
      end else begin
        e_nsr[(c + 1) % SZ] = 1'b1;
        e_smp[(c + 1) % SZ] = 16'h0000;
      end
    end
  endfunction

  task automatic tick();
    int k;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    if (sine_generate === 1'b1) rdy_sched[(cyc + 3) % SZ] = 1'b1;
    k = cyc % SZ;
    sine_ready = rdy_sched[k];
    rdy_sched[k] = 1'b0;
    load_new_note        = 1'b0;
    beat                 = 1'b0;
    generate_next_sample = 1'b0;
    exp_nsr  = e_nsr[k];  e_nsr[k]  = 1'b0;
    exp_smp  = e_smp[k];  e_smp[k]  = '0;
    exp_gen  = e_gen[k];  e_gen[k]  = 1'b0;
    exp_done = e_done[k]; e_done[k] = 1'b0;
    exp_busy = m_active && (cyc > m_load_cyc) && (cyc < m_done_cyc);
    exp_idle = (cyc >= m_idle_from);
  endtask

  task automatic load(input logic [5:0] n, input logic [5:0] d);
    note_to_load     = n;
    duration_to_load = d;
    load_new_note    = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checks++;
    if ({sine_step_size, sine_generate, sample_out, new_sample_ready, done_with_note, busy} !== 40'd0) begin
      errors++;
      $display("FAIL reset_outputs got step=%0d gen=%0b smp=%h nsr=%0b done=%0b busy=%0b want all 0",
               sine_step_size, sine_generate, sample_out, new_sample_ready, done_with_note, busy);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || done_with_note !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got busy=%0b done=%0b want 0 0", busy, done_with_note);
    end
  endtask

  task automatic test_basic_note();
    play_enable = 1'b1;
    load(6'd49, 6'd3);
    tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_load_busy got %0b want 1", busy); end
    tick();
    checks++;
    if (sine_step_size !== 20'd9612) begin
      errors++; $display("FAIL basic_step got %0d want 9612", sine_step_size);
    end
    for (int b = 0; b < 3; b++) begin
      beat = 1'b1;
      tick();
      checks++;
      if (done_with_note !== (b == 2)) begin
        errors++; $display("FAIL basic_done beat%0d got %0b want %0b", b, done_with_note, (b == 2));
      end
      tick();
    end
    checks++;
    if (done_with_note !== 1'b0 || busy !== 1'b0 || sine_step_size !== 20'd0) begin
      errors++;
      $display("FAIL basic_idle got done=%0b busy=%0b step=%0d want 0 0 0", done_with_note, busy, sine_step_size);
    end
  endtask

  task automatic test_pause();
    bit en [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    load(6'd40, 6'd4);
    tick();
    tick();
    for (int i = 0; i < 6; i++) begin
      play_enable = en[i];
      beat = 1'b1;
      if (!en[i]) generate_next_sample = 1'b1;
      tick();
      if (!en[i]) begin
        checks++;
        if (new_sample_ready !== 1'b1 || sample_out !== 16'h0 || sine_generate !== 1'b0) begin
          errors++;
          $display("FAIL pause_request got nsr=%0b smp=%h gen=%0b want 1 0000 0", new_sample_ready, sample_out, sine_generate);
        end
      end
      checks++;
      if (done_with_note !== (i == 5)) begin
        errors++; $display("FAIL pause_done step%0d got %0b want %0b", i, done_with_note, (i == 5));
      end
      play_enable = 1'b1;
      tick();
    end
  endtask

  task automatic test_rest();
    int gens = 0;
    load(6'd0, 6'd2);
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      generate_next_sample = 1'b1;
      tick();
      gens += int'(sine_generate);
      checks++;
      if (new_sample_ready !== 1'b1 || sample_out !== 16'h0) begin
        errors++; $display("FAIL rest_reply%0d got nsr=%0b smp=%h want 1 0000", i, new_sample_ready, sample_out);
      end
      tick();
      gens += int'(sine_generate);
      checks++;
      if (new_sample_ready !== 1'b0) begin
        errors++; $display("FAIL rest_strobe_width%0d got %0b want 0", i, new_sample_ready);
      end
    end
    checks++;
    if (gens != 0) begin errors++; $display("FAIL rest_no_generate got %0d want 0", gens); end
    beat = 1'b1; tick();
    beat = 1'b1; tick();
    checks++;
    if (done_with_note !== 1'b1) begin errors++; $display("FAIL rest_done got %0b want 1", done_with_note); end
    tick();
  endtask

  task automatic test_sample_relay();
    int  gen_seen = 0;
    int  nsr_seen = 0;
    bit  rdy_prev;
    stub_fixed = 1'b1;
    load(6'd20, 6'd2);
    tick();
    tick();
    generate_next_sample = 1'b1;
    tick();
    checks++;
    if (sine_generate !== 1'b1 || new_sample_ready !== 1'b0) begin
      errors++; $display("FAIL relay_generate got gen=%0b nsr=%0b want 1 0", sine_generate, new_sample_ready);
    end
    generate_next_sample = 1'b1;
    for (int i = 0; i < 12; i++) begin
      rdy_prev = sine_ready;
      tick();
      gen_seen += int'(sine_generate);
      if (new_sample_ready === 1'b1) begin
        nsr_seen++;
        checks++;
        if (rdy_prev !== 1'b1 || sample_out !== 16'h1234) begin
          errors++; $display("FAIL relay_sample got prev_ready=%0b smp=%h want 1 1234", rdy_prev, sample_out);
        end
      end
    end
    checks++;
    if (nsr_seen != 1 || gen_seen != 0) begin
      errors++; $display("FAIL relay_drop got nsr_pulses=%0d extra_gen=%0d want 1 0", nsr_seen, gen_seen);
    end
    beat = 1'b1; tick();
    beat = 1'b1; tick();
    tick();
    stub_fixed = 1'b0;
  endtask

  task automatic test_duration_zero();
    load(6'd10, 6'd0);
    tick();
    checks++;
    if (busy !== 1'b1 || done_with_note !== 1'b0) begin
      errors++; $display("FAIL dur0_load got busy=%0b done=%0b want 1 0", busy, done_with_note);
    end
    tick();
    checks++;
    if (done_with_note !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL dur0_done got done=%0b busy=%0b want 1 0", done_with_note, busy);
    end
    generate_next_sample = 1'b1;
    tick();
    checks++;
    if (new_sample_ready !== 1'b1 || sine_generate !== 1'b0 || sample_out !== 16'h0 || done_with_note !== 1'b0) begin
      errors++;
      $display("FAIL dur0_after got nsr=%0b gen=%0b smp=%h done=%0b want 1 0 0000 0",
               new_sample_ready, sine_generate, sample_out, done_with_note);
    end
  endtask

  task automatic test_load_during_play();
    load(6'd30, 6'd2);
    tick();
    tick();
    checks++;
    if (sine_step_size !== 20'd3208) begin errors++; $display("FAIL busyload_step got %0d want 3208", sine_step_size); end
    load(6'd50, 6'd9);
    tick();
    checks++;
    if (sine_step_size !== 20'd3208 || busy !== 1'b1) begin
      errors++; $display("FAIL busyload_ignored got step=%0d busy=%0b want 3208 1", sine_step_size, busy);
    end
    beat = 1'b1; tick();
    beat = 1'b1; tick();
    checks++;
    if (done_with_note !== 1'b1) begin errors++; $display("FAIL busyload_done got %0b want 1", done_with_note); end
    load(6'd5, 6'd1);
    tick();
    checks++;
    if (busy !== 1'b0 || sine_step_size !== 20'd0) begin
      errors++; $display("FAIL doneload_ignored got busy=%0b step=%0d want 0 0", busy, sine_step_size);
    end
    tick();
  endtask

  task automatic test_reset_mid_play();
    bit done_seen = 1'b0;
    load(6'd49, 6'd5);
    tick();
    tick();
    generate_next_sample = 1'b1;
    tick();
    beat = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({sine_step_size, sine_generate, sample_out, new_sample_ready, done_with_note, busy} !== 40'd0) begin
      errors++;
      $display("FAIL midreset_outputs got step=%0d gen=%0b smp=%h nsr=%0b done=%0b busy=%0b want all 0",
               sine_step_size, sine_generate, sample_out, new_sample_ready, done_with_note, busy);
    end
    repeat (3) begin
      @(posedge clk);
      #1;
      done_seen |= done_with_note;
    end
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      done_seen |= done_with_note;
    end
    checks++;
    if (done_seen !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midreset_no_done got done_seen=%0b busy=%0b want 0 0", done_seen, busy);
    end
  endtask

  task automatic test_random();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 2000; i++) begin
      play_enable          = ($urandom_range(0, 4) != 0);
      load_new_note        = ($urandom_range(0, 7) == 0);
      note_to_load         = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
      duration_to_load     = 6'($urandom_range(0, 4));
      beat                 = ($urandom_range(0, 4) == 0);
      generate_next_sample = ($urandom_range(0, 2) == 0);
      tick();
      checks++;
      if (new_sample_ready !== exp_nsr) begin
        errors++; $display("FAIL rand_nsr cyc%0d got %0b want %0b", cyc, new_sample_ready, exp_nsr);
      end
      if (exp_nsr) begin
        checks++;
        if (sample_out !== exp_smp) begin
          errors++; $display("FAIL rand_sample cyc%0d got %h want %h", cyc, sample_out, exp_smp);
        end
      end
      checks++;
      if (sine_generate !== exp_gen) begin
        errors++; $display("FAIL rand_gen cyc%0d got %0b want %0b", cyc, sine_generate, exp_gen);
      end
      checks++;
      if (done_with_note !== exp_done) begin
        errors++; $display("FAIL rand_done cyc%0d got %0b want %0b", cyc, done_with_note, exp_done);
      end
      checks++;
      if (busy !== exp_busy) begin
        errors++; $display("FAIL rand_busy cyc%0d got %0b want %0b", cyc, busy, exp_busy);
      end
      if (exp_idle) begin
        checks++;
        if (sine_step_size !== 20'd0) begin
          errors++; $display("FAIL rand_idle_step cyc%0d got %0d want 0", cyc, sine_step_size);
        end
      end
    end
  endtask

  initial begin
    reset                = 1'b1;
    play_enable          = 1'b0;
    note_to_load         = '0;
    duration_to_load     = '0;
    load_new_note        = 1'b0;
    beat                 = 1'b0;
    generate_next_sample = 1'b0;
    sine_ready           = 1'b0;
    sine_sample          = '0;
    stub_fixed           = 1'b0;
    test_reset();
    test_basic_note();
    test_pause();
    test_rest();
    test_sample_relay();
    test_duration_zero();
    test_load_during_play();
    test_reset_mid_play();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout simulation did not finish within 1 ms");
    $fatal(1);
  end

endmodule
